fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
//
// PURPOSE
//  Instruction fetch stage feeding decode_unit. Owns the PC and drives the instruction side
//  of datapath_cache_if (iREN/iaddr, ihit/iload). Buffers fetched words with their NPC in a
//  small queue toward decode under a valid/ready handshake. Applies the pcSel redirects that
//  decode produces (PC_JUMP/PC_BR/PC_JR), flushing wrong-path words. Stops fetching on halt.
//
// PARAMETERS
//  PC_INIT    32'h0  PC value loaded at reset
//  BUF_DEPTH  2      instruction queue entries (power of two, >=2)
//
// PORTS
//  CLK           in   1   clock, all state on rising edge
//  nRST          in   1   reset, synchronous, active-low
//  iREN          out  1   instruction read request to cache
//  iaddr         out  32  instruction address (word aligned, [1:0]=0)
//  ihit          in   1   cache completes request this cycle
//  iload         in   32  instruction word, valid when ihit
//  ins_valid     out  1   queue head valid toward decode
//  ins           out  32  queue head instruction word
//  ins_npc       out  32  queue head fetch address + 4
//  ins_ready     in   1   decode consumes queue head this cycle
//  redirect      in   1   decode requests PC change (qualified by pcSel != PC_NPC)
//  pcSel         in   2   pcMux: PC_NPC, PC_JUMP, PC_BR, PC_JR
//  redirect_npc  in   32  NPC of the redirecting instruction
//  immJ26        in   26  jump target field
//  imm16         in   16  branch offset field
//  jr_addr       in   32  register-sourced jump target
//  halt          in   1   decode saw HALT
//  halted        out  1   sticky: fetch stopped
//
// BEHAVIOUR
//  - Reset (nRST=0 at edge): PC=PC_INIT, queue count=0, state=FETCH, halted=0. While nRST=0
//    iREN=0 and ins_valid=0 combinationally.
//  - States: FETCH, HALTED. FETCH->HALTED on halt=1; HALTED exits only via reset.
//  - iREN = (state==FETCH) && (count < BUF_DEPTH) && !redirect_eff && !halt; iaddr = PC.
//    Hold iaddr stable while iREN=1 and ihit=0 (wait states unbounded).
//  - push = iREN && ihit: enqueue {iload, PC+4}; PC <= PC+4 same edge. Latency: word seen
//    on ins at earliest the cycle after ihit.
//  - pop = ins_valid && ins_ready. Simultaneous push+pop: count unchanged, order kept.
//    Full queue: iREN=0; a pop that cycle does not re-enable iREN until next cycle.
//  - redirect_eff = redirect && pcSel!=PC_NPC. On redirect_eff (no halt): flush queue
//    (count=0, ins_valid=0 next cycle), no push, PC <= target:
//      PC_JUMP: {redirect_npc[31:28], immJ26, 2'b00}
//      PC_BR:   redirect_npc + {{14{imm16[15]}}, imm16, 2'b00}, 32-bit wrap
//      PC_JR:   {jr_addr[31:2], 2'b00}
//    A pop coincident with redirect is allowed (head belongs to the consumer).
//  - halt: same-edge flush, state=HALTED, halted=1, iREN=0 from next cycle; halt overrides
//    redirect and any coincident ihit (word dropped). halt ignored while HALTED.
//  - PC+4 wraps 32'hFFFF_FFFC -> 0. Outputs ins/ins_npc are don't-care when ins_valid=0.
//
// STRUCTURE
//  - pcMux already in mux_types_pkg; add fetch_state_t {FETCH, HALTED} to cpu_types_pkg.
//  - Sub-module fetch_buffer: BUF_DEPTH-entry sync FIFO of {word_t ins, word_t npc} with
//    push/pop/flush, count, full/empty; FSM, PC and target math stay in fetch_unit.
//
// TESTING
//  1 Reset: nRST=0 two cycles -> iREN=0, ins_valid=0, halted=0; after release iREN=1,
//    iaddr=0x0.
//  2 Stream: ihit=1 every cycle, ins_ready=1, iload=0x20010001,0x20020002,.. -> iaddr 0,4,8;
//    ins in order one cycle later, ins_npc 4,8,12.
//  3 Backpressure: ins_ready=0, ihit=1 -> two pushes, then iREN=0, iaddr holds 0x8;
//    ins_ready=1 one cycle -> one pop, iREN=1 next cycle, no duplicate or lost word.
//  4 Jump: redirect=1, pcSel=PC_JUMP, redirect_npc=0x00000104, immJ26=0x40, ihit=1 same
//    cycle -> next iaddr=0x100, ins_valid=0, coincident iload never appears on ins.
//  5 Branch/JR: PC_BR redirect_npc=0x200, imm16=0xFFFF -> iaddr=0x1FC; PC_JR jr_addr=0x333
//    -> iaddr=0x330; redirect with pcSel=PC_NPC -> no flush, sequential fetch continues.
//  6 Halt: halt=1 with redirect=1 and ihit=1 -> halted=1, iREN=0 forever, ins_valid=0;
//    later halt pulses ignored; nRST=0 restarts fetch at 0x0 with halted=0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction fetch stage: PC mux select, fetch FSM state,
// queue entry layout and the redirect target calculation.
package fetch_unit_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    PC_NPC  = 2'd0,
    PC_JUMP = 2'd1,
    PC_BR   = 2'd2,
    PC_JR   = 2'd3
  } pc_sel_t;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  typedef struct packed {
    word_t ins;
    word_t npc;
  } fetch_entry_t;

  localparam word_t PC_STEP = 32'd4;

  // Branch offsets are word offsets relative to the NPC of the branch itself.
  function automatic word_t pc_target(input pc_sel_t     sel,
                                      input word_t       npc,
                                      input logic [25:0] imm_j26,
                                      input logic [15:0] imm16,
                                      input word_t       jr_addr);
    word_t tgt;
    case (sel)
      PC_JUMP: tgt = {npc[31:28], imm_j26, 2'b00};
      PC_BR:   tgt = npc + {{14{imm16[15]}}, imm16, 2'b00};
      PC_JR:   tgt = {jr_addr[31:2], 2'b00};
      default: tgt = npc;
    endcase
    return tgt;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage bus: instruction-cache request side plus the decode-facing queue
// head, redirect and halt controls. master = fetch unit, slave = cache/decode.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic        iREN;
  word_t       iaddr;
  logic        ihit;
  word_t       iload;

  logic        ins_valid;
  word_t       ins;
  word_t       ins_npc;
  logic        ins_ready;

  logic        redirect;
  pc_sel_t     pcSel;
  word_t       redirect_npc;
  logic [25:0] immJ26;
  logic [15:0] imm16;
  word_t       jr_addr;
  logic        halt;
  logic        halted;

  modport master (
    output iREN, iaddr, ins_valid, ins, ins_npc, halted,
    input  ihit, iload, ins_ready, redirect, pcSel, redirect_npc,
           immJ26, imm16, jr_addr, halt
  );

  modport slave (
    input  iREN, iaddr, ins_valid, ins, ins_npc, halted,
    output ihit, iload, ins_ready, redirect, pcSel, redirect_npc,
           immJ26, imm16, jr_addr, halt
  );

endinterface

// File: rtl/fetch_unit_buffer.sv
// Fetch buffer: DEPTH-entry synchronous FIFO of {instruction, npc} between
// the cache response and decode. Flush takes priority over push and pop.
module fetch_unit_buffer
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_entry,
  output fetch_entry_t rd_entry,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign rd_entry = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wr_entry;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues cache reads, queues fetched words
// toward decode, applies decode redirects and stops permanently on halt.
//
//   state  | meaning
//   FETCH  | issuing reads whenever the queue has room
//   HALTED | HALT seen; no further reads until reset
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter word_t PC_INIT   = 32'h0,
  parameter int    BUF_DEPTH = 2
) (
  input logic          CLK,
  input logic          nRST,
  fetch_unit_if.master bus
);

  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;

  logic         redirect_eff;
  logic         running;
  logic         halt_take;
  logic         redir_take;
  logic         flush;
  logic         push;
  logic         pop;
  logic         buf_full;
  logic         buf_empty;
  fetch_entry_t head;

  assign redirect_eff = bus.redirect && (bus.pcSel != PC_NPC);
  assign running      = nRST && (state_q == FETCH);
  assign halt_take    = running && bus.halt;
  assign redir_take   = running && redirect_eff && !bus.halt;
  assign flush        = halt_take || redir_take;

  // A pop in the same cycle as a full queue does not re-open the request slot.
  assign bus.iREN      = running && !buf_full && !redirect_eff && !bus.halt;
  assign bus.iaddr     = pc_q;
  assign push          = bus.iREN && bus.ihit;

  assign bus.ins_valid = nRST && !buf_empty;
  assign bus.ins       = head.ins;
  assign bus.ins_npc   = head.npc;
  assign pop           = bus.ins_valid && bus.ins_ready;

  assign bus.halted    = (state_q == HALTED);

  fetch_unit_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_buffer (
    .CLK      (CLK),
    .nRST     (nRST),
    .push     (push),
    .pop      (pop),
    .flush    (flush),
    .wr_entry ('{ins: bus.iload, npc: pc_q + PC_STEP}),
    .rd_entry (head),
    .full     (buf_full),
    .empty    (buf_empty)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (halt_take) begin
      state_d = HALTED;
    end else if (redir_take) begin
      pc_d = pc_target(bus.pcSel, bus.redirect_npc, bus.immJ26, bus.imm16, bus.jr_addr);
    end else if (push) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= FETCH;
      pc_q    <= PC_INIT;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: a queue-based model predicts the
// request side each cycle and the expected word stream seen by decode.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int    DEPTH   = 2;
  localparam word_t PC_RST  = 32'h0;

  typedef struct {
    bit          rst_n;
    bit          ihit;
    word_t       iload;
    bit          ready;
    bit          redirect;
    logic [1:0]  sel;
    word_t       rnpc;
    logic [25:0] j26;
    logic [15:0] imm;
    word_t       jr;
    bit          halt;
  } stim_t;

  logic clk  = 1'b0;
  logic nrst = 1'b0;

  fetch_unit_if bus();

  fetch_unit #(
    .PC_INIT   (PC_RST),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int           n_tests = 0;
  int           n_fail  = 0;
  word_t        m_pc    = PC_RST;
  bit           m_halted = 1'b0;
  fetch_entry_t exp_q[$];
  bit           d_chk  = 1'b0;
  word_t        d_addr = '0;

  task automatic chk(input string name, input word_t act, input word_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.rst_n = 1'b1; s.ihit = 1'b0; s.iload = '0; s.ready = 1'b0;
    s.redirect = 1'b0; s.sel = 2'd0; s.rnpc = '0; s.j26 = '0; s.imm = '0;
    s.jr = '0; s.halt = 1'b0;
    return s;
  endfunction

  function automatic word_t model_target(input logic [1:0] sel, input word_t npc,
                                         input logic [25:0] j26, input logic [15:0] imm,
                                         input word_t jr);
    word_t t;
    case (sel)
      2'd1:    t = (npc & 32'hF000_0000) | (word_t'(j26) * 4);
      2'd2:    t = npc + word_t'($signed(imm) * 4);
      2'd3:    t = jr & 32'hFFFF_FFFC;
      default: t = npc;
    endcase
    return t;
  endfunction

  // Monitor: every handshake at the queue head must match the oldest expected word.
  always @(negedge clk) begin
    #2;
    if (bus.ins_valid === 1'b1 && bus.ins_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("pop_unexpected", bus.ins, 32'hDEAD_BEEF);
      end else begin
        fetch_entry_t e;
        e = exp_q.pop_front();
        chk("ins", bus.ins, e.ins);
        chk("ins_npc", bus.ins_npc, e.npc);
      end
    end
  end

  task automatic step(input stim_t s);
    bit redir, exp_ren;
    @(negedge clk);
    nrst             = s.rst_n;
    bus.ihit         = s.ihit;
    bus.iload        = s.iload;
    bus.ins_ready    = s.ready;
    bus.redirect     = s.redirect;
    bus.pcSel        = pc_sel_t'(s.sel);
    bus.redirect_npc = s.rnpc;
    bus.immJ26       = s.j26;
    bus.imm16        = s.imm;
    bus.jr_addr      = s.jr;
    bus.halt         = s.halt;
    #1;
    redir   = s.redirect && (s.sel != 2'd0);
    exp_ren = s.rst_n && !m_halted && (exp_q.size() < DEPTH) && !redir && !s.halt;
    chk("iREN", 32'(bus.iREN), 32'(exp_ren));
    chk("ins_valid", 32'(bus.ins_valid), 32'(s.rst_n && exp_q.size() != 0));
    if (s.rst_n) begin
      chk("iaddr", bus.iaddr, m_pc);
      chk("halted", 32'(bus.halted), 32'(m_halted));
    end
    if (d_chk) begin
      chk("directed_iaddr", bus.iaddr, d_addr);
      d_chk = 1'b0;
    end
    #2;
    if (!s.rst_n) begin
      m_pc = PC_RST;
      m_halted = 1'b0;
      exp_q.delete();
    end else if (!m_halted) begin
      if (s.halt) begin
        exp_q.delete();
        m_halted = 1'b1;
      end else if (redir) begin
        exp_q.delete();
        m_pc = model_target(s.sel, s.rnpc, s.j26, s.imm, s.jr);
      end else if (exp_ren && s.ihit) begin
        exp_q.push_back('{ins: s.iload, npc: m_pc + 32'd4});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic do_reset();
    stim_t s;
    s = idle();
    s.rst_n = 1'b0;
    step(s);
    step(s);
  endtask

  task automatic expect_addr(input word_t a);
    d_chk  = 1'b1;
    d_addr = a;
  endtask

  initial begin
    stim_t s;
    bus.ihit = 1'b0; bus.iload = '0; bus.ins_ready = 1'b0; bus.redirect = 1'b0;
    bus.pcSel = PC_NPC; bus.redirect_npc = '0; bus.immJ26 = '0; bus.imm16 = '0;
    bus.jr_addr = '0; bus.halt = 1'b0;

    // Reset, then first request at PC_INIT
    do_reset();
    expect_addr(32'h0);
    step(idle());

    // Continuous stream
    do_reset();
    for (int k = 0; k < 6; k++) begin
      s = idle(); s.ihit = 1'b1; s.ready = 1'b1;
      s.iload = 32'h2000_0000 + word_t'(k + 1) * 32'h0001_0001;
      if (k < 3) expect_addr(word_t'(k) * 4);
      step(s);
    end

    // Backpressure: queue fills, request stalls at 0x8, single pop reopens next cycle
    do_reset();
    for (int k = 0; k < 4; k++) begin
      s = idle(); s.ihit = 1'b1; s.iload = 32'h3000_0000 + word_t'(k);
      if (k >= 2) expect_addr(32'h8);
      step(s);
    end
    s = idle(); s.ihit = 1'b1; s.ready = 1'b1; s.iload = 32'h3000_00AA;
    step(s);
    for (int k = 0; k < 3; k++) begin
      s = idle(); s.ihit = 1'b1; s.ready = (k == 2); s.iload = 32'h3100_0000 + word_t'(k);
      step(s);
    end

    // Jump with coincident hit
    do_reset();
    s = idle(); s.ihit = 1'b1; s.iload = 32'h4000_0001; step(s);
    s = idle(); s.ihit = 1'b1; s.redirect = 1'b1; s.sel = 2'd1; s.rnpc = 32'h0000_0104;
    s.j26 = 26'h40; s.iload = 32'hBAD0_0001; step(s);
    expect_addr(32'h100);
    s = idle(); s.ready = 1'b1; step(s);

    // Branch backwards, register jump, and a non-qualifying redirect
    s = idle(); s.redirect = 1'b1; s.sel = 2'd2; s.rnpc = 32'h200; s.imm = 16'hFFFF; step(s);
    expect_addr(32'h1FC);
    s = idle(); s.ihit = 1'b1; s.ready = 1'b1; s.iload = 32'h5000_0001; step(s);
    s = idle(); s.redirect = 1'b1; s.sel = 2'd3; s.jr = 32'h333; s.ready = 1'b1; step(s);
    expect_addr(32'h330);
    s = idle(); s.ihit = 1'b1; s.ready = 1'b1; s.iload = 32'h5000_0002; step(s);
    s = idle(); s.ihit = 1'b1; s.redirect = 1'b1; s.sel = 2'd0; s.ready = 1'b1;
    s.iload = 32'h5000_0003; step(s);
    expect_addr(32'h338);
    s = idle(); s.ready = 1'b1; step(s);

    // Halt overrides redirect and hit; later halts ignored; reset restarts
    s = idle(); s.ihit = 1'b1; s.iload = 32'h6000_0001; step(s);
    s = idle(); s.halt = 1'b1; s.redirect = 1'b1; s.sel = 2'd1; s.ihit = 1'b1;
    s.iload = 32'hBAD0_0002; step(s);
    for (int k = 0; k < 6; k++) begin
      s = idle(); s.ihit = 1'b1; s.ready = 1'b1; s.halt = (k % 2 == 0); step(s);
    end
    do_reset();
    expect_addr(32'h0);
    step(idle());

    // Randomized traffic
    for (int k = 0; k < 4000; k++) begin
      s = idle();
      s.rst_n    = ($urandom_range(0, 249) != 0);
      s.ihit     = ($urandom_range(0, 2) != 0);
      s.iload    = $urandom();
      s.ready    = ($urandom_range(0, 2) != 0);
      s.redirect = ($urandom_range(0, 9) == 0);
      s.sel      = 2'($urandom_range(0, 3));
      s.rnpc     = $urandom() & 32'hFFFF_FFFC;
      s.j26      = 26'($urandom());
      s.imm      = 16'($urandom());
      s.jr       = $urandom();
      s.halt     = ($urandom_range(0, 299) == 0);
      if (m_halted && $urandom_range(0, 19) == 0) s.rst_n = 1'b0;
      step(s);
    end

    step(idle());
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
